// File: rtl/fetch_pkg.sv
// Shared constants for the instruction-fetch front end.
package fetch_pkg;

  localparam int          INSN_W       = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0;
  localparam logic [31:0] NOP_INSN     = 32'h0;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-side bus: instruction ROM port plus the fetch/decode valid-stall link.
interface fetch_unit_if
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int IMEM_AW = 12
);
  logic [IMEM_AW-1:0] imem_addr;
  logic [INSN_W-1:0]  imem_q;
  logic               stall;
  logic               redirect;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               fd_valid;
  logic [ADDR_W-1:0]  fd_pc;
  logic [INSN_W-1:0]  fd_insn;

  modport master (
    output imem_addr, fd_valid, fd_pc, fd_insn,
    input  imem_q, stall, redirect, redirect_pc
  );

  modport slave (
    input  imem_addr, fd_valid, fd_pc, fd_insn,
    output imem_q, stall, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_skid_buf.sv
// Single-entry pc+insn holding register; flush beats load, load beats unload.
module fetch_skid_buf
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              load_i,
  input  logic              unload_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [INSN_W-1:0] insn_i,
  output logic              valid_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [INSN_W-1:0] insn_o
);
  logic              valid_q;
  logic [ADDR_W-1:0] pc_q;
  logic [INSN_W-1:0] insn_q;

  always_ff @(posedge clk) begin
    if (clear) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      insn_q  <= NOP_INSN;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      pc_q    <= pc_i;
      insn_q  <= insn_i;
    end else if (unload_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign insn_o  = insn_q;
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the PC, drives the 1-cycle ROM and feeds
// decode through an output register backed by one skid entry.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                IMEM_AW  = 12,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic         clk,
  input  logic         clear,
  fetch_unit_if.master bus
);
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic              fd_valid_q, fd_valid_d;
  logic [ADDR_W-1:0] fd_pc_q, fd_pc_d;
  logic [INSN_W-1:0] fd_insn_q, fd_insn_d;

  logic              skid_valid, skid_load, skid_unload, skid_flush;
  logic [ADDR_W-1:0] skid_pc;
  logic [INSN_W-1:0] skid_insn;

  logic              consume, out_free, issue;
  logic [1:0]        occ;

  fetch_skid_buf #(.ADDR_W(ADDR_W)) u_skid (
    .clk      (clk),
    .clear    (clear),
    .load_i   (skid_load),
    .unload_i (skid_unload),
    .flush_i  (skid_flush),
    .pc_i     (inflight_pc_q),
    .insn_i   (bus.imem_q),
    .valid_o  (skid_valid),
    .pc_o     (skid_pc),
    .insn_o   (skid_insn)
  );

  always_comb begin
    consume       = fd_valid_q & ~bus.stall;
    out_free      = ~fd_valid_q | consume;
    occ           = {1'b0, fd_valid_q} + {1'b0, skid_valid} + {1'b0, inflight_q};
    issue         = ~bus.redirect & ((occ - {1'b0, consume}) < 2'd2);

    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    fd_valid_d    = fd_valid_q;
    fd_pc_d       = fd_pc_q;
    fd_insn_d     = fd_insn_q;
    skid_load     = 1'b0;
    skid_unload   = 1'b0;
    skid_flush    = 1'b0;

    if (bus.redirect) begin
      // The return arriving this cycle belongs to the old stream and is dropped.
      skid_flush    = 1'b1;
      fd_valid_d    = 1'b0;
      inflight_d    = 1'b1;
      inflight_pc_d = bus.redirect_pc;
      pc_d          = bus.redirect_pc + ADDR_W'(1);
    end else begin
      if (issue) begin
        inflight_d    = 1'b1;
        inflight_pc_d = pc_q;
        pc_d          = pc_q + ADDR_W'(1);
      end
      if (out_free) begin
        if (skid_valid) begin
          fd_valid_d  = 1'b1;
          fd_pc_d     = skid_pc;
          fd_insn_d   = skid_insn;
          skid_load   = inflight_q;
          skid_unload = ~inflight_q;
        end else if (inflight_q) begin
          fd_valid_d  = 1'b1;
          fd_pc_d     = inflight_pc_q;
          fd_insn_d   = bus.imem_q;
        end else begin
          fd_valid_d  = 1'b0;
        end
      end else if (inflight_q) begin
        skid_load = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      fd_valid_q    <= 1'b0;
      fd_pc_q       <= '0;
      fd_insn_q     <= NOP_INSN;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      fd_valid_q    <= fd_valid_d;
      fd_pc_q       <= fd_pc_d;
      fd_insn_q     <= fd_insn_d;
    end
  end

  // Issue throttling keeps at most two words owned by fetch at any time.
  always_ff @(posedge clk) begin
    if (!clear) assert (occ != 2'd3);
  end

  assign bus.imem_addr = bus.redirect ? bus.redirect_pc[IMEM_AW-1:0] : pc_q[IMEM_AW-1:0];
  assign bus.fd_valid  = fd_valid_q;
  assign bus.fd_pc     = fd_pc_q;
  assign bus.fd_insn   = fd_insn_q;
endmodule
